// File: rtl/myo_spi_pkg.sv
// Shared types and defaults for the myocontrol SPI responder.
// Holds the FSM state enum, default sizes and the index-width helper.
package myo_spi_pkg;

  localparam int DEF_WORD_WIDTH  = 16;
  localparam int DEF_FRAME_WORDS = 12;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/myo_spi_responder_pin_sync.sv
// 2-flop synchroniser plus registered rise/fall detector for one pin.
// Ports: clk, reset_n, din (async) -> level, rise, fall (clk domain).
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s2_q <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_q <= s2;
      rise <= s2 & ~s2_q;
      fall <= ~s2 & s2_q;
    end
  end

  assign level = s2;

endmodule

// File: rtl/myo_spi_responder.sv
// SPI mode-0 responder emulating one myocontrol motor board.
// Ports: SPI pins, host status-buffer write, rx word stream, frame status.
module myo_spi_responder
  import myo_spi_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ss_n,
  input  logic                              sck,
  input  logic                              mosi,
  output logic                              miso,
  output logic                              miso_oe,
  input  logic                              tx_wr_en,
  input  logic [idx_width(FRAME_WORDS)-1:0] tx_wr_addr,
  input  logic [WORD_WIDTH-1:0]             tx_wr_data,
  output logic                              rx_valid,
  output logic [WORD_WIDTH-1:0]             rx_data,
  output logic [idx_width(FRAME_WORDS)-1:0] rx_index,
  output logic                              frame_done,
  output logic                              frame_abort,
  output logic                              overrun,
  output logic                              busy
);

  localparam int IW = idx_width(FRAME_WORDS);
  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam int NW = IW + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);
  localparam logic [NW-1:0] FW_N = NW'(FRAME_WORDS);
  localparam logic [IW-1:0] IDX_MAX = IW'(FRAME_WORDS - 1);

  logic ss_rise, ss_fall, sck_rise, sck_fall, mosi_lvl;
  logic unused_ss_lvl, unused_sck_lvl;
  logic unused_mosi_rise, unused_mosi_fall;

  spi_pin_sync #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset_n(reset_n), .din(ss_n),
    .level(unused_ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset_n(reset_n), .din(sck),
    .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .din(mosi),
    .level(mosi_lvl), .rise(unused_mosi_rise),
    .fall(unused_mosi_fall)
  );

  state_t state, state_next;
  logic [CW-1:0] bit_cnt, bit_next;
  logic [NW-1:0] word_cnt, word_next;
  logic [WORD_WIDTH-1:0] sh_in, sh_in_next;
  logic [WORD_WIDTH-1:0] sh_out, sh_out_next;
  logic [WORD_WIDTH-1:0] rx_data_next, next_word;
  logic [IW-1:0] rx_index_next;
  logic miso_next, oe_next, rx_valid_next;
  logic done_next, abort_next, ovr_next, snap_take;

  logic [WORD_WIDTH-1:0] shadow [FRAME_WORDS];
  logic [WORD_WIDTH-1:0] active [FRAME_WORDS];
  logic [WORD_WIDTH-1:0] snap   [FRAME_WORDS];

  // Shadow contents with this cycle's write folded in, so a write that
  // lands on the snapshot cycle is captured (write-first).
  always_comb begin
    for (int i = 0; i < FRAME_WORDS; i++) begin
      snap[i] = shadow[i];
      if (tx_wr_en && tx_wr_addr == IW'(i)) snap[i] = tx_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FRAME_WORDS; i++) begin
      if (!reset_n) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end else begin
        shadow[i] <= snap[i];
        if (snap_take) active[i] <= snap[i];
      end
    end
  end

  always_comb begin
    next_word = '0;
    if (word_cnt < FW_N) next_word = active[word_cnt[IW-1:0]];
  end

  always_comb begin
    state_next    = state;
    bit_next      = bit_cnt;
    word_next     = word_cnt;
    sh_in_next    = sh_in;
    sh_out_next   = sh_out;
    miso_next     = miso;
    oe_next       = miso_oe;
    rx_valid_next = 1'b0;
    rx_data_next  = rx_data;
    rx_index_next = rx_index;
    done_next     = 1'b0;
    abort_next    = 1'b0;
    ovr_next      = overrun;
    snap_take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next  = SHIFT;
          snap_take   = 1'b1;
          bit_next    = '0;
          word_next   = '0;
          ovr_next    = 1'b0;
          oe_next     = 1'b1;
          sh_out_next = snap[0];
          miso_next   = snap[0][WORD_WIDTH-1];
        end
      end
      SHIFT: begin
        // ss_n rise takes priority over any sck edge in the same cycle.
        if (ss_rise) begin
          state_next = IDLE;
          done_next  = (bit_cnt == '0);
          abort_next = (bit_cnt != '0);
          oe_next    = 1'b0;
          miso_next  = 1'b0;
        end else if (sck_rise) begin
          sh_in_next = {sh_in[WORD_WIDTH-2:0], mosi_lvl};
          if (bit_cnt == LAST_BIT) begin
            bit_next      = '0;
            rx_valid_next = 1'b1;
            rx_data_next  = {sh_in[WORD_WIDTH-2:0], mosi_lvl};
            if (word_cnt >= FW_N) begin
              rx_index_next = IDX_MAX;
              ovr_next      = 1'b1;
            end else begin
              rx_index_next = word_cnt[IW-1:0];
              word_next     = word_cnt + 1'b1;
            end
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else if (sck_fall) begin
          // bit_cnt is 0 only right after a word completed.
          if (bit_cnt == '0) begin
            sh_out_next = next_word;
            miso_next   = next_word[WORD_WIDTH-1];
          end else begin
            sh_out_next = {sh_out[WORD_WIDTH-2:0], 1'b0};
            miso_next   = sh_out[WORD_WIDTH-2];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      sh_in       <= '0;
      sh_out      <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_index    <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_next;
      word_cnt    <= word_next;
      sh_in       <= sh_in_next;
      sh_out      <= sh_out_next;
      miso        <= miso_next;
      miso_oe     <= oe_next;
      rx_valid    <= rx_valid_next;
      rx_data     <= rx_data_next;
      rx_index    <= rx_index_next;
      frame_done  <= done_next;
      frame_abort <= abort_next;
      overrun     <= ovr_next;
    end
  end

  assign busy = (state == SHIFT);

endmodule
